// File: rtl/regbank_wb_ctrl_if.sv
// Write-back requester bus: per-requester valid/addr/data with a per-requester grant.
interface regbank_wb_ctrl_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regbank_wb_ctrl.sv
// Round-robin write-back arbiter driving the register bank write port from a registered
// stage, plus a pending-write scoreboard for RAW/WAW hazard detection at issue.
module regbank_wb_ctrl #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  regbank_wb_ctrl_if.slave      req_if,
  output logic [AW-1:0]         a3,
  output logic [DW-1:0]         wd3,
  output logic                  we3,
  input  logic                  claim_valid,
  input  logic [AW-1:0]         claim_addr,
  output logic                  claim_ready,
  input  logic [AW-1:0]         q1_addr,
  input  logic [AW-1:0]         q2_addr,
  output logic                  q1_busy,
  output logic                  q2_busy
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NEXT = 2 ** PW;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [DW-1:0]   wd3_q, wd3_d;
  logic            we3_q, we3_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            gnt_valid;
  logic [PW-1:0]   gnt_idx;
  logic [NEXT-1:0] valid_ext;
  logic [NEXT-1:0] ready_ext;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // Rotating priority search: first valid requester at or after rr_ptr, modulo NREQ.
  always_comb begin
    int unsigned s;
    s         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    valid_ext = '0;
    valid_ext[NREQ-1:0] = req_if.req_valid;
    for (int unsigned k = 0; k < NREQ; k++) begin
      s = 32'(rr_ptr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      if (!gnt_valid && valid_ext[PW'(s)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'(s);
      end
    end
    if (rst) gnt_valid = 1'b0;
    ready_ext = '0;
    if (gnt_valid) ready_ext[gnt_idx] = 1'b1;
  end

  assign req_if.req_ready = ready_ext[NREQ-1:0];

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr = req_if.req_addr[i*AW +: AW];
        sel_data = req_if.req_data[i*DW +: DW];
      end
    end
  end

  assign claim_ready = claim_valid & ~rst & ((claim_addr == '0) | ~pending_q[claim_addr]);
  assign q1_busy     = (q1_addr != '0) & pending_q[q1_addr];
  assign q2_busy     = (q2_addr != '0) & pending_q[q2_addr];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    we3_d     = 1'b0;
    pending_d = pending_q;
    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      a3_d     = sel_addr;
      wd3_d    = sel_data;
      we3_d    = (sel_addr != '0);
    end
    // Clear before set: a claim of the register being retired is already refused.
    if (we3_q) pending_d[a3_q] = 1'b0;
    if (claim_ready && claim_addr != '0) pending_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      a3_q      <= '0;
      wd3_q     <= '0;
      we3_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      we3_q     <= we3_d;
      pending_q <= pending_d;
    end
  end

  assign a3  = a3_q;
  assign wd3 = wd3_q;
  assign we3 = we3_q;

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Directed, table-driven bench for regbank_wb_ctrl with NREQ=2 and a behavioural bank model.
module tb_regbank_wb_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic        claim_ready;
  logic [4:0]  q1_addr, q2_addr;
  logic        q1_busy, q2_busy;

  int checks;
  int failures;

  regbank_wb_ctrl_if #(.NREQ(2), .DW(32), .AW(5)) rq ();

  regbank_wb_ctrl #(.NREQ(2), .DW(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (rq),
    .a3          (a3),
    .wd3         (wd3),
    .we3         (we3),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .q1_addr     (q1_addr),
    .q2_addr     (q2_addr),
    .q1_busy     (q1_busy),
    .q2_busy     (q2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: writes any address the port presents.
  logic [31:0] bank [32];
  initial for (int i = 0; i < 32; i++) bank[i] = '0;
  always @(posedge clk) if (we3) bank[a3] <= wd3;

  typedef struct {
    logic [1:0]  rv;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        cv;
    logic [4:0]  ca;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic [1:0]  rdy;
    logic        cr;
    logic        b1;
    logic        b2;
    logic        we;
    logic [4:0]  ea3;
    logic [31:0] ewd;
  } vec_t;

  function automatic vec_t mk(logic [1:0] rv, logic [4:0] a0, logic [31:0] d0,
                              logic [4:0] a1, logic [31:0] d1, logic cv, logic [4:0] ca,
                              logic [4:0] q1, logic [4:0] q2, logic [1:0] rdy, logic cr,
                              logic b1, logic b2, logic we, logic [4:0] ea3, logic [31:0] ewd);
    vec_t v;
    v.rv = rv; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.cv = cv; v.ca = ca;
    v.q1 = q1; v.q2 = q2; v.rdy = rdy; v.cr = cr; v.b1 = b1; v.b2 = b2; v.we = we;
    v.ea3 = ea3; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic cv,
                       input logic [4:0] ca, input logic [4:0] q1, input logic [4:0] q2);
    rq.req_valid = rv;
    rq.req_addr  = {a1, a0};
    rq.req_data  = {d1, d0};
    claim_valid  = cv;
    claim_addr   = ca;
    q1_addr      = q1;
    q2_addr      = q2;
  endtask

  vec_t vecs [19];

  initial begin
    checks   = 0;
    failures = 0;

    // Cycle-by-cycle: single write (r7), register 0, round robin, WAW stall.
    vecs[0]  = mk(2'b00, 0, 0, 0, 0, 1, 7, 7, 0, 2'b00, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(2'b01, 7, 32'hDEADBEEF, 0, 0, 0, 0, 7, 0, 2'b01, 0, 1, 0, 0, 0, 0);
    vecs[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 0, 1, 0, 1, 7, 32'hDEADBEEF);
    vecs[4]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 0, 0, 0, 0, 7, 32'hDEADBEEF);
    vecs[5]  = mk(2'b10, 0, 0, 0, 32'h1234, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 7, 32'hDEADBEEF);
    vecs[6]  = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 32'h1234);
    vecs[7]  = mk(2'b11, 10, 32'hA0, 11, 32'hB1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 32'h1234);
    vecs[8]  = mk(2'b11, 12, 32'hA2, 11, 32'hB1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 10, 32'hA0);
    vecs[9]  = mk(2'b11, 12, 32'hA2, 13, 32'hB3, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 11, 32'hB1);
    vecs[10] = mk(2'b11, 14, 32'hA4, 13, 32'hB3, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 12, 32'hA2);
    vecs[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 13, 32'hB3);
    vecs[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 13, 32'hB3);
    vecs[13] = mk(2'b00, 0, 0, 0, 0, 1, 3, 3, 0, 2'b00, 1, 0, 0, 0, 13, 32'hB3);
    vecs[14] = mk(2'b00, 0, 0, 0, 0, 1, 3, 3, 0, 2'b00, 0, 1, 0, 0, 13, 32'hB3);
    vecs[15] = mk(2'b01, 3, 32'h33, 0, 0, 1, 3, 3, 0, 2'b01, 0, 1, 0, 0, 13, 32'hB3);
    vecs[16] = mk(2'b00, 0, 0, 0, 0, 1, 4, 3, 4, 2'b00, 1, 1, 0, 1, 3, 32'h33);
    vecs[17] = mk(2'b00, 0, 0, 0, 0, 1, 3, 3, 4, 2'b00, 1, 0, 1, 0, 3, 32'h33);
    vecs[18] = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 2'b00, 0, 1, 1, 0, 3, 32'h33);

    // Reset held two cycles with requests and a claim present.
    rst = 1'b1;
    drive(2'b11, 5, 32'h55, 6, 32'h66, 1, 5, 5, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rst%0d_rdy", c), 32'(rq.req_ready), 0);
      chk($sformatf("rst%0d_cr", c), 32'(claim_ready), 0);
      chk($sformatf("rst%0d_we3", c), 32'(we3), 0);
      chk($sformatf("rst%0d_a3", c), 32'(a3), 0);
      chk($sformatf("rst%0d_wd3", c), wd3, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    chk("rst_q1_busy5", 32'(q1_busy), 0);
    chk("rst_we3_after", 32'(we3), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rv, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1,
            vecs[i].cv, vecs[i].ca, vecs[i].q1, vecs[i].q2);
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 32'(rq.req_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_cr", i), 32'(claim_ready), 32'(vecs[i].cr));
      chk($sformatf("v%0d_q1b", i), 32'(q1_busy), 32'(vecs[i].b1));
      chk($sformatf("v%0d_q2b", i), 32'(q2_busy), 32'(vecs[i].b2));
      chk($sformatf("v%0d_we3", i), 32'(we3), 32'(vecs[i].we));
      chk($sformatf("v%0d_a3", i), 32'(a3), 32'(vecs[i].ea3));
      chk($sformatf("v%0d_wd3", i), wd3, vecs[i].ewd);
      @(posedge clk); #1;
    end

    chk("bank_r7", bank[7], 32'hDEADBEEF);
    chk("bank_r0", bank[0], 32'h0);
    chk("bank_r13", bank[13], 32'hB3);

    // Reset right after a transfer: output stage and pending bits (r3, r4) are discarded.
    drive(2'b01, 9, 32'h99, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    chk("mid_a_rdy", 32'(rq.req_ready), 32'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(2'b01, 9, 32'h99, 0, 0, 1, 5, 3, 4);
    @(negedge clk);
    chk("mid_b_rdy", 32'(rq.req_ready), 0);
    chk("mid_b_cr", 32'(claim_ready), 0);
    chk("mid_b_we3", 32'(we3), 1);
    chk("mid_b_a3", 32'(a3), 9);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    chk("mid_c_we3", 32'(we3), 0);
    chk("mid_c_a3", 32'(a3), 0);
    chk("mid_c_wd3", wd3, 0);
    chk("mid_c_q1b", 32'(q1_busy), 0);
    chk("mid_c_q2b", 32'(q2_busy), 0);
    @(posedge clk); #1;
    drive(2'b11, 20, 32'h20, 21, 32'h21, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_d_rdy", 32'(rq.req_ready), 32'b01);
    @(posedge clk); #1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_e_we3", 32'(we3), 1);
    chk("mid_e_a3", 32'(a3), 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
